aes_key_slot_mem: RTL

//   Parametrised multi-slot key store for the AES-XTS-256 datapath. Holds DEPTH keys of DATA_W bits,

---
 rtl/aes_key_slot_mem.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/aes_key_slot_mem.sv
// Multi-slot key store with per-slot valid bitmap, registered reads and a sequenced zeroize engine.
// Optional per-slot write lock enabled by defining AES_KEYMEM_LOCK_EN.
module aes_key_slot_mem #(
  parameter int unsigned  DATA_W = 256,
  parameter int unsigned  DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              inClk,
  input  logic              inRstN,
  input  logic              inWr,
  input  logic [ADDR_W-1:0] inWrAddr,
  input  logic [DATA_W-1:0] inWrData,
  input  logic              inRd,
  input  logic [ADDR_W-1:0] inRdAddr,
  output logic [DATA_W-1:0] outRdData,
  output logic              outRdValid,
  output logic              outRdMiss,
  input  logic              inZeroize,
  output logic              outBusy,
`ifdef AES_KEYMEM_LOCK_EN
  input  logic              inLock,
`endif
  output logic              outWrErr
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWipe = 1'b1;
  localparam logic [ADDR_W-1:0] LastSlot = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_miss_q, rd_miss_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic idle, wr_in_range, rd_in_range, wr_locked, wr_ok, rd_ok, rd_hit;

`ifdef AES_KEYMEM_LOCK_EN
  logic [DEPTH-1:0] lock_q, lock_d;
`endif

  always_comb begin
    idle        = (state_q == StIdle);
    wr_in_range = 32'(inWrAddr) < DEPTH;
    rd_in_range = 32'(inRdAddr) < DEPTH;
`ifdef AES_KEYMEM_LOCK_EN
    wr_locked   = wr_in_range && lock_q[inWrAddr];
`else
    wr_locked   = 1'b0;
`endif
    // A write coinciding with the zeroize start is rejected: the wipe would erase it anyway.
    wr_ok  = idle && inWr && wr_in_range && !inZeroize && !wr_locked;
    rd_ok  = idle && inRd;
    rd_hit = rd_ok && rd_in_range && valid_q[inRdAddr];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (inZeroize) begin
          state_d = StWipe;
          cnt_d   = '0;
          valid_d = '0;
        end else if (wr_ok) begin
          valid_d[inWrAddr] = 1'b1;
        end
      end
      StWipe: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastSlot) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory is sampled before this edge's write lands, giving read-first behaviour.
  always_comb begin
    rd_valid_d = rd_ok;
    rd_miss_d  = rd_ok && !rd_hit;
    rd_data_d  = rd_hit ? mem_q[inRdAddr] : '0;
    wr_err_d   = inWr && !wr_ok;
  end

`ifdef AES_KEYMEM_LOCK_EN
  always_comb begin
    lock_d = lock_q;
    if (idle && inZeroize) begin
      lock_d = '0;
    end else if (wr_ok && inLock) begin
      lock_d[inWrAddr] = 1'b1;
    end
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      lock_q <= '0;
    end else begin
      lock_q <= lock_d;
    end
  end
`endif

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_miss_q  <= 1'b0;
      rd_data_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      rd_valid_q <= rd_valid_d;
      rd_miss_q  <= rd_miss_d;
      rd_data_q  <= rd_data_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Key storage is deliberately not reset; the valid bitmap gates every read.
  always_ff @(posedge inClk) begin
    if (state_q == StWipe) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      mem_q[inWrAddr] <= inWrData;
    end
  end

  assign outRdData  = rd_data_q;
  assign outRdValid = rd_valid_q;
  assign outRdMiss  = rd_miss_q;
  assign outBusy    = (state_q == StWipe);
  assign outWrErr   = wr_err_q;

endmodule
